// File: rtl/mp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mp_pkg
//  Description : Shared defaults and FSM state encoding for the mpadder
//                arbiter slice.
//  Contents    : c_DEF_WIDTH   - default operand width in bits
//                c_DEF_TIMEOUT - default WAIT-cycle budget before abandoning
//                state_t       - arbiter FSM states
//  Revision    : 1.0 - initial release
// ============================================================================
package mp_pkg;

    localparam int c_DEF_WIDTH   = 1027;
    localparam int c_DEF_TIMEOUT = 31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage : mp_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin picker. With both requests high the
//                grant goes to the side the pointer favours; with one request
//                high that side wins outright. On an update strobe the
//                pointer moves away from whoever was granted.
//  Ports       : clk    - rising-edge clock
//                resetn - asynchronous active-low reset (pointer favours 0)
//                req    - request vector, bit n = requester n
//                update - a grant is being taken this cycle
//                grant  - one-hot grant (zero when no request)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    // 0: requester 0 wins a tie, 1: requester 1 wins a tie
    logic r_favourOne;

    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = r_favourOne ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_favourOne <= 1'b0;
        end else if (update && (req != 2'b00)) begin
            // Point away from the winner, so a granted requester 0 makes 1 favoured
            r_favourOne <= grant[0];
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/mpadder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mpadder_arbiter
//  Description : Shares one multi-precision adder between two requesters.
//                IDLE grants a requester and latches its operands, START
//                kicks the adder for one cycle, WAIT waits for add_done (or
//                gives up after TIMEOUT cycles and flags err), RESP pulses
//                done to the granted requester.
//  Ports       : clk, resetn           - clock / async active-low reset
//                req0/1, sub0/1        - requests and add(0)/subtract(1)
//                a0/b0/a1/b1           - requester operands (WIDTH)
//                ack0/1                - operands latched (one cycle)
//                done0/1               - result valid (one cycle)
//                result                - last captured adder result (WIDTH+1)
//                err                   - last operation timed out
//                busy                  - FSM not in IDLE
//                add_start/subtract/a/b- drive the shared adder
//                add_result/add_done   - returned by the shared adder
//  Revision    : 1.0 - initial release
// ============================================================================
module mpadder_arbiter
    import mp_pkg::*;
#(
    parameter int WIDTH   = c_DEF_WIDTH,
    parameter int TIMEOUT = c_DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req0,
    input  logic             req1,
    input  logic             sub0,
    input  logic             sub1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack0,
    output logic             ack1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH:0]   result,
    output logic             err,
    output logic             busy,
    output logic             add_start,
    output logic             add_subtract,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH:0]   add_result,
    input  logic             add_done
);

    // The counter only has to reach TIMEOUT-1: that is the last WAIT cycle
    localparam int                 c_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         w_grant;
    logic               w_take;
    logic               w_cntLast;
    logic [WIDTH-1:0]   r_opA;
    logic [WIDTH-1:0]   r_opB;
    logic               r_opSub;
    logic               r_grantOne;
    logic [c_CNT_W-1:0] r_waitCnt;
    logic [WIDTH:0]     r_result;
    logic               r_err;

    // Requests are only looked at in IDLE; anything raised later simply waits
    assign w_take    = (r_state == ST_IDLE) && (req0 || req1);
    assign w_cntLast = (r_waitCnt == c_CNT_LAST);

    rr_arbiter2 u_rrArbiter (
        .clk    (clk),
        .resetn (resetn),
        .req    ({req1, req0}),
        .update (w_take),
        .grant  (w_grant)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_take) w_next = ST_START;
            ST_START: w_next = ST_WAIT;
            ST_WAIT:  if (add_done || w_cntLast) w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_opA      <= '0;
            r_opB      <= '0;
            r_opSub    <= 1'b0;
            r_grantOne <= 1'b0;
            r_waitCnt  <= '0;
            r_result   <= '0;
            r_err      <= 1'b0;
        end else begin
            // Operands change only on a grant, so the adder inputs stay
            // stable for the whole START/WAIT window
            if (w_take) begin
                r_grantOne <= w_grant[1];
                r_opA      <= w_grant[1] ? a1 : a0;
                r_opB      <= w_grant[1] ? b1 : b0;
                r_opSub    <= w_grant[1] ? sub1 : sub0;
                r_err      <= 1'b0;
            end
            if (r_state == ST_WAIT) begin
                r_waitCnt <= r_waitCnt + c_CNT_W'(1);
                if (add_done) begin
                    r_result <= add_result;
                end else if (w_cntLast) begin
                    r_err <= 1'b1;
                end
            end else begin
                r_waitCnt <= '0;
            end
        end
    end

    // ack is combinational in the grant cycle; gating with resetn keeps it
    // low while reset is asserted even if a request is held
    assign ack0         = resetn && w_take && w_grant[0];
    assign ack1         = resetn && w_take && w_grant[1];
    assign done0        = (r_state == ST_RESP) && !r_grantOne;
    assign done1        = (r_state == ST_RESP) &&  r_grantOne;
    assign busy         = (r_state != ST_IDLE);
    assign add_start    = (r_state == ST_START);
    assign add_subtract = r_opSub;
    assign add_a        = r_opA;
    assign add_b        = r_opB;
    assign result       = r_result;
    assign err          = r_err;

endmodule : mpadder_arbiter
`default_nettype wire

// File: tb/tb_mpadder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mpadder_arbiter
//  Description : Self-checking bench for mpadder_arbiter: a directed vector
//                table, hand-written reset/stray-done sequences and a random
//                phase against a behavioural arbitration/arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mpadder_arbiter;

    localparam int W  = 1027;
    localparam int TO = 31;

    logic         clk = 1'b0;
    logic         resetn;
    logic         req0, req1, sub0, sub1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         ack0, ack1, done0, done1;
    logic [W:0]   result;
    logic         err, busy, add_start, add_subtract;
    logic [W-1:0] add_a, add_b;
    logic [W:0]   add_result;
    logic         add_done;

    mpadder_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn), .req0(req0), .req1(req1),
        .sub0(sub0), .sub1(sub1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .result(result), .err(err), .busy(busy),
        .add_start(add_start), .add_subtract(add_subtract),
        .add_a(add_a), .add_b(add_b),
        .add_result(add_result), .add_done(add_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [W:0] act, input logic [W:0] exp);
        logic [63:0] lo_a, lo_e;
        n_chk++;
        if (act !== exp) begin
            n_err++;
            lo_a = act[63:0];
            lo_e = exp[63:0];
            $display("FAIL %s: got ..%0h expected ..%0h (low 64 bits)", nm, lo_a, lo_e);
        end
    endtask

    function automatic logic [W:0] f_arith(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        return s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    // ---------------- shared adder model ----------------
    // m_lat > 0: answer m_lat cycles after add_start; m_lat == 0: never answer
    int           m_lat  = 0;
    int           m_cnt  = 0;
    int           m_viol = 0;
    logic         m_sub;
    logic [W-1:0] m_a, m_b;
    logic         m_stray = 1'b0;
    logic [W:0]   m_stray_val = '0;

    initial begin
        add_done   = 1'b0;
        add_result = '0;
        forever begin
            @(negedge clk);
            add_done = m_stray;
            if (m_stray) add_result = m_stray_val;
            if (!resetn) begin
                m_cnt = 0;
            end else if (m_cnt > 0) begin
                if (add_subtract !== m_sub || add_a !== m_a || add_b !== m_b) m_viol++;
                m_cnt--;
                if (m_cnt == 0) begin
                    add_done   = 1'b1;
                    add_result = f_arith(m_a, m_b, m_sub);
                end
            end else if (add_start === 1'b1 && m_lat > 0) begin
                m_cnt = m_lat;
                m_a   = add_a;
                m_b   = add_b;
                m_sub = add_subtract;
            end
        end
    end

    // ---------------- reference arbitration model ----------------
    int fav = 0;
    task automatic ref_pick(input logic [1:0] rq, output int g);
        if (rq == 2'b11) g = fav;
        else             g = rq[1] ? 1 : 0;
        fav = 1 - g;
    endtask

    // One transaction: raise rq, wait for ack, drop the granted req (the other
    // stays held), then wait for done. Latency is counted from the ack cycle.
    task automatic run_op(input logic [1:0] rq, input int lat, output int g, output int dn,
                          output int lt, output logic e_post, output logic s_post, output int extra);
        int t0;
        m_lat = lat;
        g = -1; dn = -1; lt = -1; e_post = 1'bx; s_post = 1'bx; extra = 0;
        @(posedge clk); #1;
        req0 = rq[0];
        req1 = rq[1];
        for (int i = 0; i < 20 && g < 0; i++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                chkb("ack_onehot", ack0 & ack1, 1'b0);
                g = ack1 ? 1 : 0;
            end
        end
        if (g < 0) begin
            chkb("ack_seen", 1'b0, 1'b1);
            return;
        end
        t0 = cyc;
        @(posedge clk); #1;
        if (g == 0) req0 = 1'b0; else req1 = 1'b0;
        @(negedge clk);
        e_post = err;
        s_post = add_start;
        for (int i = 0; i < 100 && dn < 0; i++) begin
            @(negedge clk);
            if (add_start) extra++;
            if (done0 || done1) begin
                dn = done1 ? (done0 ? 2 : 1) : 0;
                lt = cyc - t0;
            end
        end
    endtask

    typedef struct {
        logic [1:0]  rq;
        logic [31:0] a0, b0, a1, b1;
        logic        s0, s1;
        int          lat;
        int          egnt;
        int          elat;
        logic        eerr;
        logic        keep;
        logic [31:0] eres;
    } vec_t;

    vec_t       tbl [7];
    logic [W:0] exp_res;

    task automatic check_outputs_zero(input string tag);
        chkb({tag, "_ack0"}, ack0, 1'b0);
        chkb({tag, "_ack1"}, ack1, 1'b0);
        chkb({tag, "_done0"}, done0, 1'b0);
        chkb({tag, "_done1"}, done1, 1'b0);
        chkb({tag, "_add_start"}, add_start, 1'b0);
        chkb({tag, "_err"}, err, 1'b0);
        chkb({tag, "_busy"}, busy, 1'b0);
        chkw({tag, "_result"}, result, '0);
        chkw({tag, "_add_a"}, {1'b0, add_a}, '0);
        chkw({tag, "_add_b"}, {1'b0, add_b}, '0);
    endtask

    initial begin
        int g, dn, lt, extra, eg, lat, elat;
        logic ep, sp, eerr;
        logic [1:0] rq;
        bit seen;

        //              rq     a0  b0  a1   b1 s0 s1 lat g elat err keep res
        tbl[0] = '{2'b01,  5,  7,   0,  0, 0, 0, 6, 0,  8, 0, 0, 12};
        tbl[1] = '{2'b10,  0,  0,  20,  3, 0, 1, 4, 1,  6, 0, 0, 17};
        tbl[2] = '{2'b01,  9,  9,   0,  0, 0, 0, 0, 0, 33, 1, 1,  0};
        tbl[3] = '{2'b10,  0,  0, 100,  1, 0, 0, 1, 1,  3, 0, 0, 101};
        tbl[4] = '{2'b11, 40,  2,  50,  5, 1, 0, 2, 0,  4, 0, 0, 38};
        tbl[5] = '{2'b11, 40,  2,  50,  5, 1, 0, 3, 1,  5, 0, 0, 55};
        tbl[6] = '{2'b11, 40,  2,  50,  5, 1, 0, 2, 0,  4, 0, 0, 38};

        resetn = 1'b0;
        req0 = 1'b0; req1 = 1'b0; sub0 = 1'b0; sub1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        exp_res = '0;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // ---------------- directed table ----------------
        for (int i = 0; i < 7; i++) begin
            a0 = W'(tbl[i].a0); b0 = W'(tbl[i].b0); sub0 = tbl[i].s0;
            a1 = W'(tbl[i].a1); b1 = W'(tbl[i].b1); sub1 = tbl[i].s1;
            ref_pick(tbl[i].rq, eg);
            run_op(tbl[i].rq, tbl[i].lat, g, dn, lt, ep, sp, extra);
            if (!tbl[i].keep) exp_res = (W+1)'(tbl[i].eres);
            chki($sformatf("v%0d_grant", i), g, tbl[i].egnt);
            chki($sformatf("v%0d_done_who", i), dn, tbl[i].egnt);
            chki($sformatf("v%0d_latency", i), lt, tbl[i].elat);
            chkw($sformatf("v%0d_result", i), result, exp_res);
            chkb($sformatf("v%0d_err", i), err, tbl[i].eerr);
            chkb($sformatf("v%0d_err_clear_on_grant", i), ep, 1'b0);
            chkb($sformatf("v%0d_add_start", i), sp, 1'b1);
            chki($sformatf("v%0d_add_start_once", i), extra, 0);
        end
        chki("operands_stable", m_viol, 0);

        // ---------------- reset in the middle of WAIT ----------------
        m_lat = 0;
        @(posedge clk); #1;
        req1 = 1'b0; req0 = 1'b1; sub0 = 1'b0;
        a0 = W'(1000); b0 = W'(234);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = ack0;
        end
        chkb("rst_pre_ack0", seen, 1'b1);
        repeat (4) @(negedge clk);
        chkb("rst_pre_busy", busy, 1'b1);
        #1 resetn = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        fav = 0;
        exp_res = '0;
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        chkb("rst_post_done0", done0, 1'b0);
        chkb("rst_post_ack0", ack0, 1'b1);
        ref_pick(2'b01, eg);
        m_lat = 3;
        @(posedge clk); #1 req0 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = done0;
        end
        chkb("rst_post_done_seen", seen, 1'b1);
        exp_res = (W+1)'(1234);
        chkw("rst_post_result", result, exp_res);

        // ---------------- stray add_done in IDLE ----------------
        @(posedge clk); #1;
        m_stray_val = {1'b1, rand_w()};
        m_stray = 1'b1;
        @(posedge clk); #1 m_stray = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done0 || done1 || busy) seen = 1'b1;
        end
        chkb("stray_no_activity", seen, 1'b0);
        chkw("stray_result", result, exp_res);

        // ---------------- randomized phase ----------------
        for (int k = 0; k < 40; k++) begin
            rq   = 2'($urandom_range(1, 3));
            a0   = rand_w(); b0 = rand_w(); a1 = rand_w(); b1 = rand_w();
            sub0 = 1'($urandom_range(0, 1));
            sub1 = 1'($urandom_range(0, 1));
            lat  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 10));
            ref_pick(rq, eg);
            elat = (lat == 0) ? TO + 2 : lat + 2;
            eerr = (lat == 0);
            if (lat != 0) exp_res = (eg == 1) ? f_arith(a1, b1, sub1) : f_arith(a0, b0, sub0);
            run_op(rq, lat, g, dn, lt, ep, sp, extra);
            chki($sformatf("r%0d_grant", k), g, eg);
            chki($sformatf("r%0d_done_who", k), dn, eg);
            chki($sformatf("r%0d_latency", k), lt, elat);
            chkw($sformatf("r%0d_result", k), result, exp_res);
            chkb($sformatf("r%0d_err", k), err, eerr);
        end
        chki("operands_stable_final", m_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule : tb_mpadder_arbiter
`default_nettype wire

// File: doc/mpadder_arbiter.md
MPADDER_ARBITER -- requirements
Module: mpadder_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1027, giving the operand width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 31, giving the maximum WAIT cycles before abandoning an operation.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port resetn, input, 1, the reset; it is asynchronous and active-low.
REQ-005 The block SHALL have ports req0/req1, input, 1 each, operation request per requester.
REQ-006 The block SHALL have ports sub0/sub1, input, 1 each, where 1 selects a-b and 0 selects a+b.
REQ-007 The block SHALL have ports a0/b0/a1/b1, input, WIDTH each, requester operands.
REQ-008 The block SHALL have ports ack0/ack1, output, 1 each, a one-cycle pulse meaning the operands were latched.
REQ-009 The block SHALL have ports done0/done1, output, 1 each, a one-cycle pulse meaning result is valid for that requester.
REQ-010 The block SHALL have port result, output, WIDTH+1, the last adder result, held until the next capture.
REQ-011 The block SHALL have port err, output, 1, set on timeout and cleared on the next grant.
REQ-012 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 The block SHALL have ports add_start, add_subtract, add_a, add_b (WIDTH), outputs, driving the shared mpadder.
REQ-014 The block SHALL have ports add_result (WIDTH+1) and add_done (1), inputs, from the shared mpadder.

Function
REQ-015 The FSM SHALL have states IDLE, START, WAIT and RESP.
REQ-016 In IDLE with any req high, the block SHALL grant one requester, latch its a/b/sub into internal registers, pulse its ack, and go to START on the next edge.
REQ-017 If both requests are high, the grant SHALL go to the requester not granted last; the pointer resets to favour requester 0.
REQ-018 If exactly one request is high, that requester SHALL be granted regardless of the pointer, and the pointer SHALL then point away from it.
REQ-019 In START, add_start SHALL be high for exactly one cycle; the FSM then goes to WAIT.
REQ-020 add_a, add_b and add_subtract SHALL be driven from the latched registers and held stable from START until the FSM leaves WAIT.
REQ-021 In WAIT, the block SHALL count cycles from 0.
REQ-022 If add_done is high in a WAIT cycle, the block SHALL capture add_result into result on that edge, then go to RESP.
REQ-023 If the WAIT count reaches TIMEOUT without add_done, the block SHALL leave result unchanged, set err, and go to RESP.
REQ-024 In RESP, the block SHALL pulse done for the granted requester for exactly one cycle, then return to IDLE.
REQ-025 Latency SHALL be grant edge -> START (1) -> WAIT (N cycles to add_done) -> RESP, so the done pulse arrives N+2 cycles after the ack pulse.
REQ-026 A requester SHALL deassert req after ack; a req still high in IDLE SHALL count as a new request.
REQ-027 The block SHALL ignore add_done outside WAIT.
REQ-028 The block SHALL ignore requests arriving in START, WAIT or RESP, which are not lost if still held at IDLE.
REQ-029 The ack and done pulses SHALL never both be high for different requesters in the same cycle.
REQ-030 A new grant SHALL clear err on the same edge the operands are latched.

Reset
REQ-031 When resetn is low, the block SHALL go immediately to IDLE, regardless of clk.
REQ-032 While resetn is low, ack0, ack1, done0, done1, add_start, err and busy SHALL be 0, and result, the latched operands and the WAIT counter SHALL be 0.
REQ-033 Reset SHALL set the round-robin pointer to favour requester 0.
REQ-034 Reset mid-operation SHALL abort without a done pulse; a pending req SHALL be re-arbitrated after release.

Structure
REQ-035 Package mp_pkg SHALL hold the WIDTH default, the TIMEOUT default and the FSM state encoding.
REQ-036 The block SHALL use one sub-module, rr_arbiter2, a 2-way round-robin picker with the pointer register that takes req and an update strobe and returns grant.
REQ-037 The operand latches, FSM and timeout counter SHALL reside in mpadder_arbiter.

Verification
REQ-038 The bench SHALL cover a single add: req0=1, a0=5, b0=7, sub0=0; the adder model returns done after 6 cycles -> ack0, then done0 8 cycles later, result=12, err=0.
REQ-039 The bench SHALL cover a subtract: req1, a1=20, b1=3, sub1=1 -> add_subtract=1 held through WAIT, result=17, done1 only.
REQ-040 The bench SHALL cover contention: req0 and req1 rise in the same cycle, held until ack, three rounds -> grant order 0,1,0, with each done after the previous done.
REQ-041 The bench SHALL cover timeout: the adder model never asserts add_done -> RESP after 31 WAIT cycles, err=1, result unchanged, done pulses; the next grant clears err.
REQ-042 The bench SHALL cover reset mid-WAIT: resetn low for 1 cycle -> all outputs 0 asynchronously, no done; a held req0 is granted after release.
REQ-043 The bench SHALL cover a stray add_done: add_done pulsed in IDLE -> result unchanged, no done pulse.
